// File: rtl/rgb_pwm_gen_pkg.sv
// Shared definitions for the three-channel RGB PWM output stage.
package rgb_pwm_gen_pkg;

   localparam int PWM_WIDTH   = 8;
   localparam int PWM_CNT_MAX = 2**PWM_WIDTH - 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/rgb_pwm_gen_ch.sv
// One PWM channel: pending/active duty double buffer plus registered compare.
module pwm_cmp_ch
   import rgb_pwm_gen_pkg::*;
#(
   parameter int WIDTH        = PWM_WIDTH,
   parameter int DEFAULT_DUTY = 0
) (
   input  logic             clk_div,
   input  logic             rst,
   input  logic             load_i,
   input  logic             xfer_i,
   input  logic             run_i,
   input  logic             inv_i,
   input  logic [WIDTH-1:0] cnt_i,
   input  logic [WIDTH-1:0] duty_i,
   output logic             pwm_o
);

   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] act_q, act_d;
   logic             pwm_q, pwm_d;

   // Next-state: a load coinciding with a transfer bypasses the pending register.
   always_comb begin
      pend_d = load_i ? duty_i : pend_q;
      act_d  = act_q;
      if (xfer_i) begin
         act_d = load_i ? duty_i : pend_q;
      end
      pwm_d = run_i ? ((cnt_i < act_q) ^ inv_i) : inv_i;
   end

   // Duty registers and the output pin register, cleared asynchronously.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         pend_q <= WIDTH'(DEFAULT_DUTY);
         act_q  <= WIDTH'(DEFAULT_DUTY);
         pwm_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         act_q  <= act_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_gen.sv
// RGB PWM generator top: period counter, run/drain FSM, transfer and ack strobes.
module rgb_pwm_gen
   import rgb_pwm_gen_pkg::*;
#(
   parameter int WIDTH        = PWM_WIDTH,
   parameter int CNT_MAX      = 2**WIDTH - 2,
   parameter int DEFAULT_DUTY = 0
) (
   input  logic             clk_div,
   input  logic             rst,
   input  logic             en,
   input  logic             inv,
   input  logic             duty_load,
   input  logic [WIDTH-1:0] duty_r,
   input  logic [WIDTH-1:0] duty_g,
   input  logic [WIDTH-1:0] duty_b,
   output logic             pwm_r,
   output logic             pwm_g,
   output logic             pwm_b,
   output logic             period_start,
   output logic             load_ack,
   output logic             busy
);

   localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(CNT_MAX);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             pend_v_q, pend_v_d;
   logic             ps_q, ps_d;
   logic             ack_q;
   logic             run_w, wrap_w, xfer_w;

   // Illegal encoding 3 decodes as not running, so it behaves like IDLE for one edge.
   assign run_w  = (state_q == RUN) || (state_q == DRAIN);
   assign wrap_w = run_w && (cnt_q == CNT_LAST);
   assign xfer_w = (!run_w || wrap_w) && (pend_v_q || duty_load);

   // Next state, counter and strobes; the counter is parked at 0 outside RUN/DRAIN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en) state_d = RUN;
         RUN:     if (!en) state_d = DRAIN;
         DRAIN:   if (en) state_d = RUN;
                  else if (wrap_w) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cnt_d    = (!run_w || wrap_w) ? '0 : cnt_q + 1'b1;
      pend_v_d = xfer_w ? 1'b0 : (duty_load ? 1'b1 : pend_v_q);
      ps_d     = (state_d != IDLE) && (cnt_d == '0);
   end

   // FSM, counter and registered control strobes.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pend_v_q <= 1'b0;
         ps_q     <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_v_q <= pend_v_d;
         ps_q     <= ps_d;
         ack_q    <= xfer_w;
      end
   end

   pwm_cmp_ch #(.WIDTH(WIDTH), .DEFAULT_DUTY(DEFAULT_DUTY)) u_ch_r (
      .clk_div(clk_div), .rst(rst), .load_i(duty_load), .xfer_i(xfer_w),
      .run_i(run_w), .inv_i(inv), .cnt_i(cnt_q), .duty_i(duty_r), .pwm_o(pwm_r)
   );

   pwm_cmp_ch #(.WIDTH(WIDTH), .DEFAULT_DUTY(DEFAULT_DUTY)) u_ch_g (
      .clk_div(clk_div), .rst(rst), .load_i(duty_load), .xfer_i(xfer_w),
      .run_i(run_w), .inv_i(inv), .cnt_i(cnt_q), .duty_i(duty_g), .pwm_o(pwm_g)
   );

   pwm_cmp_ch #(.WIDTH(WIDTH), .DEFAULT_DUTY(DEFAULT_DUTY)) u_ch_b (
      .clk_div(clk_div), .rst(rst), .load_i(duty_load), .xfer_i(xfer_w),
      .run_i(run_w), .inv_i(inv), .cnt_i(cnt_q), .duty_i(duty_b), .pwm_o(pwm_b)
   );

   assign period_start = ps_q;
   assign load_ack     = ack_q;
   assign busy         = run_w;

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Self-checking bench for rgb_pwm_gen against a cycle-level behavioural model.
module tb_rgb_pwm_gen;

   logic       clk_div = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       inv = 1'b0;
   logic       duty_load = 1'b0;
   logic [7:0] duty_r = 8'd0;
   logic [7:0] duty_g = 8'd0;
   logic [7:0] duty_b = 8'd0;
   logic       pwm_r, pwm_g, pwm_b, period_start, load_ack, busy;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model: period of 255 cycles, duty double buffer, run/drain flags
   bit        m_run, m_drain, m_pv;
   int        m_cnt;
   int        m_act[3];
   int        m_pend[3];
   bit [5:0]  m_exp;

   // per-window tallies of observed output activity
   int t_r, t_g, t_b, t_ps, t_ack;

   rgb_pwm_gen dut (
      .clk_div(clk_div), .rst(rst), .en(en), .inv(inv), .duty_load(duty_load),
      .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
      .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
      .period_start(period_start), .load_ack(load_ack), .busy(busy)
   );

   always #5 clk_div = ~clk_div;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_drain = 0; m_pv = 0; m_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         m_act[c] = 0;
         m_pend[c] = 0;
      end
      m_exp = '0;
   endtask

   // advance the model by one clock edge using the inputs currently applied
   task automatic model_edge();
      bit busy_now, wrap, boundary, xfer, nb, ps;
      bit [2:0] p;
      int d[3];
      d[0] = int'(duty_r); d[1] = int'(duty_g); d[2] = int'(duty_b);
      busy_now = m_run || m_drain;
      wrap     = busy_now && (m_cnt == 254);
      boundary = !busy_now || wrap;
      xfer     = boundary && (m_pv || duty_load);
      for (int c = 0; c < 3; c++)
         p[2-c] = busy_now ? ((m_cnt < m_act[c]) ^ inv) : inv;
      if (!busy_now) begin
         m_run = en; m_drain = 0;
      end else if (m_run) begin
         if (!en) begin m_run = 0; m_drain = 1; end
      end else begin
         if (en) begin m_run = 1; m_drain = 0; end
         else if (wrap) m_drain = 0;
      end
      m_cnt = boundary ? 0 : m_cnt + 1;
      if (xfer) begin
         for (int c = 0; c < 3; c++) m_act[c] = duty_load ? d[c] : m_pend[c];
         m_pv = 0;
      end else if (duty_load) begin
         for (int c = 0; c < 3; c++) m_pend[c] = d[c];
         m_pv = 1;
      end
      nb = m_run || m_drain;
      ps = nb && (m_cnt == 0);
      m_exp = {p, ps, xfer, nb};
   endtask

   task automatic step();
      @(posedge clk_div);
      model_edge();
      #1;
      chk("outputs", {26'd0, pwm_r, pwm_g, pwm_b, period_start, load_ack, busy}, {26'd0, m_exp});
      t_r += int'(pwm_r); t_g += int'(pwm_g); t_b += int'(pwm_b);
      t_ps += int'(period_start); t_ack += int'(load_ack);
   endtask

   task automatic step_to(input int target);
      int k = 0;
      while (m_cnt != target && k < 600) begin
         step();
         k++;
      end
      if (k >= 600) begin
         n_cmp++; n_bad++;
         $error("FAIL step_to timeout observed=%0d expected=%0d", m_cnt, target);
      end
   endtask

   task automatic wait_ps();
      int k = 0;
      do begin
         step();
         k++;
      end while (!period_start && k < 600);
      if (!period_start) begin
         n_cmp++; n_bad++;
         $error("FAIL wait_ps timeout observed=0 expected=1");
      end
   endtask

   // count pin activity over one full period, starting just after a period_start sample
   task automatic window();
      t_r = 0; t_g = 0; t_b = 0; t_ps = 0;
      repeat (255) step();
   endtask

   task automatic load(input int r, input int g, input int b);
      duty_r = 8'(r); duty_g = 8'(g); duty_b = 8'(b);
      duty_load = 1'b1;
      step();
      duty_load = 1'b0;
   endtask

   function automatic int pick_duty();
      case ($urandom_range(0, 3))
         0: return 0;
         1: return 255;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      int n;
      model_reset();
      #2 rst = 1'b1;
      #1 chk("reset_outputs", {26'd0, pwm_r, pwm_g, pwm_b, period_start, load_ack, busy}, 32'd0);
      @(negedge clk_div);
      rst = 1'b0;
      repeat (3) step();

      // load in IDLE while starting: immediate transfer, ack next cycle
      en = 1'b1;
      t_ack = 0;
      load(64, 128, 0);
      chk("idle_load_ack", load_ack, 1);
      chk("first_period_start", period_start, 1);
      window();
      chk("red_64", t_r, 64);
      chk("green_128", t_g, 128);
      chk("blue_0", t_b, 0);
      chk("ps_per_period", t_ps, 1);

      // mid-period load waits for the period boundary
      step_to(10);
      t_ack = 0;
      load(200, 128, 0);
      wait_ps();
      chk("ack_at_boundary", load_ack, 1);
      window();
      chk("red_200", t_r, 200);
      chk("ack_once", t_ack, 1);

      // load exactly on the wrap edge bypasses pending
      step_to(254);
      t_ack = 0;
      load(255, 128, 0);
      chk("bypass_ack", load_ack, 1);
      window();
      chk("red_255", t_r, 255);
      chk("bypass_ack_once", t_ack, 1);

      // inverted polarity: duty 0 is constant high, duty 255 constant low
      inv = 1'b1;
      load(64, 0, 128);
      wait_ps();
      window();
      chk("inv_green_duty0", t_g, 255);
      chk("inv_red_64", t_r, 191);
      load(64, 255, 128);
      wait_ps();
      window();
      chk("inv_green_duty255", t_g, 0);
      inv = 1'b0;

      // drop en at cnt 100: drain finishes the period, then IDLE
      step_to(100);
      en = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (busy && n < 400);
      chk("drain_len", n, 155);
      inv = 1'b1;
      step();
      chk("idle_pwm_inv1", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd7);
      inv = 1'b0;
      step();
      chk("idle_pwm_inv0", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd0);

      // en re-raised during DRAIN must not restart the counter
      en = 1'b1;
      step();
      step_to(50);
      en = 1'b0;
      repeat (20) step();
      en = 1'b1;
      t_ps = 0;
      step_to(254);
      step();
      chk("no_restart", t_ps, 1);

      // async reset mid-period with a pending load
      step_to(30);
      load(99, 99, 99);
      repeat (5) step();
      #2 rst = 1'b1;
      #1 chk("rst_async", {26'd0, pwm_r, pwm_g, pwm_b, period_start, load_ack, busy}, 32'd0);
      model_reset();
      en = 1'b1;
      @(negedge clk_div);
      rst = 1'b0;
      t_ack = 0;
      step();
      window();
      chk("post_rst_no_ack", t_ack, 0);
      chk("post_rst_default_r", t_r, 0);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) en = ~en;
         if ($urandom_range(0, 299) == 0) inv = ~inv;
         if ($urandom_range(0, 39) == 0) begin
            duty_r = 8'(pick_duty()); duty_g = 8'(pick_duty()); duty_b = 8'(pick_duty());
            duty_load = 1'b1;
         end
         step();
         duty_load = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
